game_mode_ctrl: RTL
===================

GAME_MODE_CTRL -- requirements
Module: game_mode_ctrl

Interface
REQ-001 SHALL have parameter N_MODES, default 4, meaning the number of game-mode blocks sequenced (2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the clk cycles of stable raw input required before a button level is accepted.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, meaning the display-blanking interval on mode entry and exit.
REQ-004 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port btn_mode_raw  input  1  unsynchronised mode button (select next / exit).
REQ-007 SHALL have port btn_confirm_raw  input  1  unsynchronised confirm button.
REQ-008 SHALL have port btn_go_raw  input  1  unsynchronised shared go/stop button.
REQ-009 SHALL have port mode_led  input  16*N_MODES  LED vector of mode k in bits [16k+15:16k].
REQ-010 SHALL have port mode_seg  input  16*N_MODES  seg_data of mode k in bits [16k+15:16k].
REQ-011 SHALL have port active  output  N_MODES  one-hot-or-zero enable per mode block.
REQ-012 SHALL have port btn_go  output  N_MODES  debounced go/stop level, routed only to the running mode.
REQ-013 SHALL have port led  output  16  board LEDs.
REQ-014 SHALL have port seg_data  output  16  four 4-bit digit codes, 4'hF = blank.
REQ-015 SHALL have port cur_mode  output  2  index of the selected mode.

Function
REQ-016 SHALL pass each raw button through a 2-FF synchroniser and a debouncer; a press is a single-cycle pulse on the rising edge of the debounced level.
REQ-017 SHALL implement the states MENU, ENTER, RUN and EXIT.
REQ-018 MENU behaviour:
- active = 0.
- led = one-hot at bit sel.
- seg_data = {8'hFF, 4'h0, sel+1}.
REQ-019 In MENU, a mode press SHALL set sel to (sel+1) mod N_MODES, wrapping from N_MODES-1 to 0.
REQ-020 In MENU, a confirm press SHALL go to ENTER and load the blank counter with BLANK_CYCLES-1.
REQ-021 If mode and confirm presses coincide in MENU, confirm SHALL win and sel SHALL stay unchanged.
REQ-022 ENTER and EXIT behaviour:
- led = 0, seg_data = 16'hFFFF, active = 0.
- Counter decrements once per cycle.
- At 0: ENTER goes to RUN, EXIT goes to MENU.
- Total dwell is exactly BLANK_CYCLES cycles.
REQ-023 RUN behaviour:
- active[sel] = 1, all other bits 0.
- led and seg_data are registered copies of mode slice sel, 1-cycle latency.
- btn_go[sel] = debounced go level, other btn_go bits 0.
REQ-024 In RUN, a mode press SHALL go to EXIT and reload the counter; confirm presses SHALL be ignored.
REQ-025 All button presses SHALL be ignored in ENTER and EXIT, and no press SHALL be queued.
REQ-026 btn_go SHALL be 0 in every state except RUN; a held go button SHALL NOT produce a level on btn_go before RUN is reached.
REQ-027 cur_mode SHALL always equal sel.
REQ-028 sel SHALL change only in MENU.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On reset assertion the block SHALL immediately force the following:
- state = MENU, sel = 0.
- active = 0, btn_go = 0.
- led = 16'h0001, seg_data = 16'hFF01.
- Debouncers and counters cleared.
REQ-031 Reset in any state, including mid-RUN or mid-blank, SHALL take effect without a blanking interval.
REQ-032 The first press after reset release SHALL require a full DEBOUNCE_CYCLES of stable input.

Structure
REQ-033 State encoding, the blank digit code 4'hF and the menu-prefix code 4'h0 SHALL live in the shared game package.
REQ-034 Debounce SHALL be a sub-module btn_debounce containing the synchroniser, stability counter, level output and press pulse, instantiated three times.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, BLANK_CYCLES=3, N_MODES=4.
REQ-035 Reset, then 4 mode presses -> sel 1,2,3,0, and seg_data ends at 16'hFF01 with led = 16'h0001.
REQ-036 A 2-cycle glitch on btn_mode_raw -> no sel change.
REQ-037 sel=1, confirm press -> exactly 3 cycles of seg_data=FFFF with active=0, then active=4'b0010, and the next cycle led equals mode_led[31:16].
REQ-038 In RUN, a go press -> only btn_go[1] high; then a mode press -> 3 blank cycles, then MENU with active=0 and sel still 1.
REQ-039 In MENU, simultaneous mode and confirm presses -> ENTER with sel unchanged.
REQ-040 Reset asserted mid-ENTER and mid-RUN -> same cycle active=0, seg_data=FF01, state MENU.

Source files
------------

// File: rtl/game_mode_ctrl_pkg.sv
// Shared definitions for the game-mode sequencer: state encoding,
// display digit codes and helpers for the menu display.
package game_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_ENTER = 2'd1,
        ST_RUN   = 2'd2,
        ST_EXIT  = 2'd3
    } state_t;

    localparam logic [3:0]  DIGIT_BLANK = 4'hF;
    localparam logic [3:0]  DIGIT_MENU  = 4'h0;
    localparam logic [15:0] SEG_BLANK   = {4{DIGIT_BLANK}};

    // Menu display: two blank digits, the menu prefix, then the 1-based mode number.
    function automatic logic [15:0] menu_seg(input logic [1:0] sel);
        return {DIGIT_BLANK, DIGIT_BLANK, DIGIT_MENU, {2'b00, sel} + 4'd1};
    endfunction

    function automatic logic [15:0] menu_led(input logic [1:0] sel);
        return 16'd1 << sel;
    endfunction

endpackage

// File: rtl/game_mode_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability down-counter, accepted
// level and a one-cycle press pulse on the level's rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], raw};
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= CNT_LOAD;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q[1] == level) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                level <= sync_q[1];
                press <= sync_q[1];
                cnt   <= CNT_LOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_mode_ctrl.sv
// Game-mode sequencer: menu selection, blanked entry/exit and routing of
// the selected mode block's LEDs, display and go button.
//
// state    | meaning
// MENU     | browsing modes, display shows selected mode number
// ENTER    | display blanked before starting the selected mode
// RUN      | selected mode owns LEDs, display and go button
// EXIT     | display blanked before returning to the menu
module game_mode_ctrl
    import game_mode_ctrl_pkg::*;
#(
    parameter int N_MODES         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLANK_CYCLES    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_mode_raw,
    input  logic                 btn_confirm_raw,
    input  logic                 btn_go_raw,
    input  logic [16*N_MODES-1:0] mode_led,
    input  logic [16*N_MODES-1:0] mode_seg,
    output logic [N_MODES-1:0]   active,
    output logic [N_MODES-1:0]   btn_go,
    output logic [15:0]          led,
    output logic [15:0]          seg_data,
    output logic [1:0]           cur_mode
);

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES - 1);

    logic mode_level, mode_press;
    logic confirm_level, confirm_press;
    logic go_level, go_press;
    logic unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .raw(btn_mode_raw),
        .level(mode_level), .press(mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
        .clk(clk), .reset(reset), .raw(btn_confirm_raw),
        .level(confirm_level), .press(confirm_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_go (
        .clk(clk), .reset(reset), .raw(btn_go_raw),
        .level(go_level), .press(go_press)
    );

    // Mode/confirm act on press pulses only, go is passed through as a level.
    assign unused_levels = mode_level ^ confirm_level ^ go_press;

    state_t        state;
    logic [1:0]    sel;
    logic [BW-1:0] blank_cnt;
    logic [15:0]   run_led;
    logic [15:0]   run_seg;

    assign cur_mode = sel;

    // Pick the selected mode's LED and display slices.
    always_comb begin
        run_led = '0;
        run_seg = '0;
        for (int k = 0; k < N_MODES; k++) begin
            if (sel == 2'(k)) begin
                run_led = mode_led[16*k +: 16];
                run_seg = mode_seg[16*k +: 16];
            end
        end
    end

    // Sequencer state, selection, blank timer and registered outputs of the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_MENU;
            sel       <= 2'd0;
            blank_cnt <= '0;
            active    <= '0;
            btn_go    <= '0;
            led       <= menu_led(2'd0);
            seg_data  <= menu_seg(2'd0);
        end else begin
            active   <= '0;
            btn_go   <= '0;
            led      <= '0;
            seg_data <= SEG_BLANK;
            case (state)
                ST_MENU: begin
                    led      <= menu_led(sel);
                    seg_data <= menu_seg(sel);
                    if (confirm_press) begin
                        state     <= ST_ENTER;
                        blank_cnt <= BLANK_LOAD;
                    end else if (mode_press) begin
                        sel <= (sel == 2'(N_MODES - 1)) ? 2'd0 : sel + 2'd1;
                    end
                end
                ST_ENTER: begin
                    if (blank_cnt == '0) state <= ST_RUN;
                    else                 blank_cnt <= blank_cnt - 1'b1;
                end
                ST_RUN: begin
                    for (int k = 0; k < N_MODES; k++) begin
                        active[k] <= (sel == 2'(k));
                        btn_go[k] <= go_level && (sel == 2'(k));
                    end
                    led      <= run_led;
                    seg_data <= run_seg;
                    if (mode_press) begin
                        state     <= ST_EXIT;
                        blank_cnt <= BLANK_LOAD;
                    end
                end
                ST_EXIT: begin
                    if (blank_cnt == '0) state <= ST_MENU;
                    else                 blank_cnt <= blank_cnt - 1'b1;
                end
                default: state <= ST_MENU;
            endcase
        end
    end

endmodule
